// File: rtl/clk_divider.sv
// Even-ratio clock divider: registered 50%-duty o_clk with period FACTOR clk cycles.
// Define CLK_DIVIDER_ASSERT_EN to compile the simulation-only protocol checker.
module clk_divider #(
  parameter int FACTOR = 10
) (
  input  logic clk,
  input  logic rst,
  output logic o_clk
);

  localparam int HALF = FACTOR / 32'sd2;
  localparam int CW   = (HALF > 32'sd1) ? $clog2(HALF) : 32'sd1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 32'sd1);

  if ((FACTOR < 32'sd2) || ((FACTOR % 32'sd2) != 32'sd0)) begin : g_bad_factor
    $fatal(1, "clk_divider: FACTOR must be even and >= 2");
  end

  logic [CW-1:0] cnt_r;
  logic          o_clk_r;

  // Half-period counter; the output flop toggles when a half period completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      o_clk_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      o_clk_r <= ~o_clk_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      o_clk_r <= o_clk_r;
    end
  end

  assign o_clk = o_clk_r;

`ifdef CLK_DIVIDER_ASSERT_EN
  clk_divider_checker #(
    .FACTOR (FACTOR),
    .CW     (CW)
  ) u_checker (
    .clk   (clk),
    .rst   (rst),
    .cnt   (cnt_r),
    .o_clk (o_clk_r)
  );
`endif

endmodule

`ifdef CLK_DIVIDER_ASSERT_EN
// Simulation-only observer of the divider's counter and output phase behaviour.
module clk_divider_checker #(
  parameter int FACTOR = 10,
  parameter int CW     = 3
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] cnt,
  input logic          o_clk
);

  localparam int HALF = FACTOR / 32'sd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 32'sd1);

  logic        started_r;
  logic        prev_o_r;
  logic        prev_rst_r;
  logic        clean_r;
  logic [31:0] run_r;
  logic        phase_err_s;

  // Phase-length tracker; a phase is only judged if it began and ended with a toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      started_r <= 1'b1;
    end else begin
      started_r <= started_r;
    end
    prev_o_r   <= o_clk;
    prev_rst_r <= rst;
    if (o_clk != prev_o_r) begin
      run_r   <= 32'd1;
      clean_r <= !prev_rst_r && !rst;
    end else begin
      run_r   <= run_r + 32'd1;
      clean_r <= rst ? 1'b0 : clean_r;
    end
  end

  assign phase_err_s = (o_clk != prev_o_r) && clean_r && !prev_rst_r && (run_r != 32'(HALF));

  a_cnt_range: assert property (@(posedge clk) disable iff (!started_r)
    cnt <= CNT_LAST)
    else $error("clk_divider: cnt out of range at %0t", $time);

  a_toggle_src: assert property (@(posedge clk) disable iff (!started_r)
    $changed(o_clk) |-> ($past(rst) || ($past(!rst) && ($past(cnt) == CNT_LAST))))
    else $error("clk_divider: o_clk changed off terminal count at %0t", $time);

  a_rst_low: assert property (@(posedge clk) disable iff (!started_r)
    rst |=> !o_clk)
    else $error("clk_divider: o_clk high after reset edge at %0t", $time);

  a_phase_len: assert property (@(posedge clk) disable iff (!started_r)
    !phase_err_s)
    else $error("clk_divider: phase length differs from FACTOR/2 at %0t", $time);

endmodule
`endif

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider at FACTOR=10 and FACTOR=2 sharing clk and rst.
module tb_clk_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_clk10;
  logic o_clk2;

  always #5 clk = ~clk;

  clk_divider #(.FACTOR(10)) dut10 (.clk(clk), .rst(rst), .o_clk(o_clk10));
  clk_divider #(.FACTOR(2))  dut2  (.clk(clk), .rst(rst), .o_clk(o_clk2));

  typedef struct {
    logic rst;
    logic exp;
  } vec_t;

  typedef struct {
    logic chk10;
    logic exp10;
    logic chk2;
    logic exp2;
    string name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input int n);
    repeat (n) vecs.push_back('{rst: r, exp: e});
  endtask

  // Drive one edge; expectations queue at drive time and retire once the edge has settled.
  task automatic step(input logic r, input logic c10, input logic e10,
                      input logic c2, input logic e2, input string name);
    sb_t s;
    @(negedge clk);
    rst = r;
    sbq.push_back('{chk10: c10, exp10: e10, chk2: c2, exp2: e2, name: name});
    @(posedge clk);
    #1;
    s = sbq.pop_front();
    if (s.chk10) check({s.name, "_f10"}, o_clk10, s.exp10);
    if (s.chk2)  check({s.name, "_f2"},  o_clk2,  s.exp2);
  endtask

  initial begin
    logic [11:0] f2_pat;
    logic        prev;
    int          rises;
    int          falls;
    int          run;

    // Reset then 5 low / 5 high, reset mid-high phase, then restart.
    add(1'b1, 1'b0, 1);
    add(1'b0, 1'b0, 4);
    add(1'b0, 1'b1, 5);
    add(1'b0, 1'b0, 5);
    add(1'b0, 1'b1, 3);
    add(1'b1, 1'b0, 1);
    add(1'b0, 1'b0, 4);
    add(1'b0, 1'b1, 5);
    add(1'b0, 1'b0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, 1'b1, vecs[i].exp, 1'b0, 1'b0, $sformatf("tbl%0d", i));
    end

    // FACTOR=2 toggles every edge after reset; FACTOR=10 checked alongside.
    f2_pat = 12'b010101010101;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "div2_rst");
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, ((k >= 5) && (k <= 9)) ? 1'b1 : 1'b0,
           1'b1, f2_pat[k-1], $sformatf("div2_e%0d", k));
    end

    // Free-run 100 edges after reset: count transitions and phase lengths.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "run_rst");
    prev  = 1'b0;
    rises = 0;
    falls = 0;
    run   = 1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      if (o_clk10 !== prev) begin
        if (o_clk10 === 1'b1) rises++;
        else falls++;
        check($sformatf("phase_len_e%0d", k), (run == 5) ? 1'b1 : 1'b0, 1'b1);
        run  = 1;
        prev = o_clk10;
      end else begin
        run++;
      end
    end
    checks++;
    if (rises != 10) begin
      errors++;
      $display("FAIL rise_count: got %0d expected 10", rises);
    end
    checks++;
    if (falls != 10) begin
      errors++;
      $display("FAIL fall_count: got %0d expected 10", falls);
    end

    // Advance into a high phase, then hold reset for 20 edges.
    repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "adv");
    check("pre_hold_high", o_clk10, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, $sformatf("hold%0d", k));
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "release_e1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
